// File: rtl/reset_seq_gen_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_gen_pkg : FSM state encoding and counter-width helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reset_seq_gen_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_ASSERT = 2'd0,
    ST_WAIT   = 2'd1,
    ST_GAP    = 2'd2,
    ST_DONE   = 2'd3
  } seq_state_t;

  // Width needed to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reset_seq_gen_if.sv
// ---------------------------------------------------------------------------
// reset_seq_gen_if : trigger inputs, stage handshake and sequenced reset outputs
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface reset_seq_gen_if #(
  parameter int N_STAGES = 3
);
  logic                btn_n;
  logic                sw_rst_req;
  logic [N_STAGES-1:0] stage_ready;
  logic [N_STAGES-1:0] rst_out_n;
  logic                busy;
  logic                seq_done;
  logic                timeout_err;

  modport master (
    output btn_n, sw_rst_req, stage_ready,
    input  rst_out_n, busy, seq_done, timeout_err
  );

  modport slave (
    input  btn_n, sw_rst_req, stage_ready,
    output rst_out_n, busy, seq_done, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/reset_seq_gen_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce : 2-FF synchronizer plus DEB_CYCLES stability filter, idles high
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debounce
  import reset_seq_gen_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  wire logic clk,
  input  wire logic n_rst,
  input  wire logic btn_n,
  output logic      level
);

  localparam int            CW       = cnt_w(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      // Any sample matching the accepted level restarts the stability count.
      if (sync2 != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync2;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/reset_seq_gen.sv
// ---------------------------------------------------------------------------
// reset_seq_gen : merged button/software reset, hold, then staged release.
// Optional ready handshake with timeout: RESET_SEQ_GEN_READY_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reset_seq_gen
  import reset_seq_gen_pkg::*;
#(
  parameter int N_STAGES       = 3,
  parameter int DEB_CYCLES     = 16,
  parameter int HOLD_CYCLES    = 8,
  parameter int STEP_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  wire logic       clk,
  input  wire logic       n_rst,
  reset_seq_gen_if.slave  bus
);

  localparam int            HW        = cnt_w(HOLD_CYCLES);
  localparam int            SW        = cnt_w(STEP_CYCLES);
  localparam int            KW        = cnt_w(N_STAGES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);

  logic                btn_level;
  logic                trigger;
  logic                last_gap;
  seq_state_t          state_q, state_nx;
  logic [HW-1:0]       hold_q, hold_nx;
  logic [SW-1:0]       step_q, step_nx;
  logic [KW-1:0]       k_q, k_nx;
  logic [N_STAGES-1:0] rst_q, rst_nx;
  logic                busy_q, busy_nx;
  logic                done_q, done_nx;

`ifdef RESET_SEQ_GEN_READY_EN
  localparam int            TW        = cnt_w(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam seq_state_t    FIRST_STP = ST_WAIT;

  logic [TW-1:0] to_q, to_nx;
  logic          err_q, err_nx;
  logic          ready_k;
  logic          wait_to;

  assign ready_k = bus.stage_ready[k_q];
  assign wait_to = (to_q == TO_LAST);
`else
  localparam seq_state_t FIRST_STP = ST_GAP;

  logic unused_ready;
  assign unused_ready = ^bus.stage_ready;
`endif

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .n_rst (n_rst),
    .btn_n (bus.btn_n),
    .level (btn_level)
  );

  assign trigger  = ~btn_level | bus.sw_rst_req;
  assign last_gap = (int'(k_q) == N_STAGES - 2);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_ASSERT;
      hold_q  <= '0;
      step_q  <= '0;
      k_q     <= '0;
      rst_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
`ifdef RESET_SEQ_GEN_READY_EN
      to_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_nx;
      hold_q  <= hold_nx;
      step_q  <= step_nx;
      k_q     <= k_nx;
      rst_q   <= rst_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
`ifdef RESET_SEQ_GEN_READY_EN
      to_q    <= to_nx;
      err_q   <= err_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state_q;
    hold_nx  = hold_q;
    step_nx  = step_q;
    k_nx     = k_q;
`ifdef RESET_SEQ_GEN_READY_EN
    to_nx    = '0;
`endif
    if (trigger) begin
      state_nx = ST_ASSERT;
      hold_nx  = '0;
      step_nx  = '0;
      k_nx     = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (hold_q == HOLD_LAST) begin
            hold_nx  = '0;
            k_nx     = '0;
            state_nx = (N_STAGES == 1) ? ST_DONE : FIRST_STP;
          end else begin
            hold_nx = hold_q + 1'b1;
          end
        end
`ifdef RESET_SEQ_GEN_READY_EN
        ST_WAIT: begin
          if (ready_k || wait_to) begin
            state_nx = ST_GAP;
          end else begin
            to_nx = to_q + 1'b1;
          end
        end
`endif
        ST_GAP: begin
          if (step_q == STEP_LAST) begin
            step_nx  = '0;
            k_nx     = k_q + 1'b1;
            state_nx = last_gap ? ST_DONE : FIRST_STP;
          end else begin
            step_nx = step_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Each release shifts one more '1' in from bit 0, so released bits stay high.
  always_comb begin
    rst_nx  = rst_q;
    done_nx = done_q;
`ifdef RESET_SEQ_GEN_READY_EN
    err_nx  = err_q;
`endif
    if (trigger) begin
      rst_nx  = '0;
      done_nx = 1'b0;
`ifdef RESET_SEQ_GEN_READY_EN
      err_nx  = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (hold_q == HOLD_LAST) begin
            rst_nx  = N_STAGES'(1);
            done_nx = (N_STAGES == 1);
          end
        end
`ifdef RESET_SEQ_GEN_READY_EN
        ST_WAIT: begin
          if (!ready_k && wait_to) begin
            err_nx = 1'b1;
          end
        end
`endif
        ST_GAP: begin
          if (step_q == STEP_LAST) begin
            rst_nx  = N_STAGES'({rst_q, 1'b1});
            done_nx = last_gap;
          end
        end
        default: ;
      endcase
    end
    busy_nx = ~&rst_nx;
  end

  assign bus.rst_out_n = rst_q;
  assign bus.busy      = busy_q;
  assign bus.seq_done  = done_q;
`ifdef RESET_SEQ_GEN_READY_EN
  assign bus.timeout_err = err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_reset_seq_gen.sv
// ---------------------------------------------------------------------------
// tb_reset_seq_gen : directed self-checking bench for reset_seq_gen
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reset_seq_gen;

`ifdef RESET_SEQ_GEN_READY_EN
  localparam int X = 1;   // one WAIT cycle per stage when ready is already high
`else
  localparam int X = 0;
`endif

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  reset_seq_gen_if #(.N_STAGES(3)) bus ();

  reset_seq_gen #(
    .N_STAGES       (3),
    .DEB_CYCLES     (16),
    .HOLD_CYCLES    (8),
    .STEP_CYCLES    (4),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (!bus.seq_done && n < limit) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.seq_done), 1);
    check({tag, "_rst"}, 32'(bus.rst_out_n), 7);
  endtask

  task automatic sw_pulse;
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
  endtask

  initial begin
    int glitches;
    bus.btn_n       = 1'b1;
    bus.sw_rst_req  = 1'b0;
    bus.stage_ready = (X == 1) ? 3'b111 : 3'b000;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out", 32'(bus.rst_out_n), 0);
    check("rst_busy", 32'(bus.busy), 1);
    check("rst_done", 32'(bus.seq_done), 0);
    check("rst_err", 32'(bus.timeout_err), 0);

    // Power-up release timeline
    @(negedge clk);
    n_rst = 1'b1;
    for (int e = 1; e <= 16 + 2 * X; e++) begin
      tick();
      if (e == 7)          check("pu_e7", 32'(bus.rst_out_n), 0);
      if (e == 8)          check("pu_e8", 32'(bus.rst_out_n), 1);
      if (e == 11 + X)     check("pu_s1_pre", 32'(bus.rst_out_n), 1);
      if (e == 12 + X)     check("pu_s1", 32'(bus.rst_out_n), 3);
      if (e == 15 + 2 * X) begin
        check("pu_s2_pre", 32'(bus.rst_out_n), 3);
        check("pu_done_pre", 32'(bus.seq_done), 0);
        check("pu_busy_pre", 32'(bus.busy), 1);
      end
      if (e == 16 + 2 * X) begin
        check("pu_s2", 32'(bus.rst_out_n), 7);
        check("pu_done", 32'(bus.seq_done), 1);
        check("pu_busy", 32'(bus.busy), 0);
      end
    end

    // Bouncing button: runs of 5 never reach the 16-sample threshold
    glitches = 0;
    for (int i = 0; i < 80; i++) begin
      bus.btn_n = (i < 60) ? (((i / 5) % 2) == 1) : 1'b1;
      tick();
      if (bus.rst_out_n != 3'b111) glitches++;
    end
    check("bounce_glitch", 32'(glitches), 0);

    // Solid press: outputs drop 19 edges after the first low sample
    bus.btn_n = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      tick();
      if (e == 18) check("press_e18", 32'(bus.rst_out_n), 7);
      if (e == 19) begin
        check("press_e19", 32'(bus.rst_out_n), 0);
        check("press_busy", 32'(bus.busy), 1);
      end
    end
    tick();
    bus.btn_n = 1'b1;
    wait_done("press_recover", 100);

    // Software trigger, then a second one mid-sequence
    sw_pulse();
    check("sw_edge", 32'(bus.rst_out_n), 0);
    check("sw_done", 32'(bus.seq_done), 0);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 7) check("sw_e7", 32'(bus.rst_out_n), 0);
      if (e == 8) check("sw_e8", 32'(bus.rst_out_n), 1);
    end
    sw_pulse();
    check("mid_trig", 32'(bus.rst_out_n), 0);
    check("mid_busy", 32'(bus.busy), 1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      if (e == 7) check("mid_e7", 32'(bus.rst_out_n), 0);
      if (e == 8) check("mid_e8", 32'(bus.rst_out_n), 1);
    end
    wait_done("mid_recover", 50);

`ifdef RESET_SEQ_GEN_READY_EN
    // Handshake: stage_ready[0] arrives 10 WAIT cycles late
    bus.stage_ready = 3'b000;
    sw_pulse();
    repeat (8) tick();
    check("hs_s0", 32'(bus.rst_out_n), 1);
    repeat (10) tick();
    check("hs_hold", 32'(bus.rst_out_n), 1);
    bus.stage_ready[0] = 1'b1;
    tick();
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 3) check("hs_s1_pre", 32'(bus.rst_out_n), 1);
      if (e == 4) check("hs_s1", 32'(bus.rst_out_n), 3);
    end
    bus.stage_ready = 3'b111;
    wait_done("hs_done", 20);
    check("hs_err", 32'(bus.timeout_err), 0);

    // Timeout: no ready at all
    bus.stage_ready = 3'b000;
    sw_pulse();
    repeat (8) tick();
    for (int w = 1; w <= 64; w++) begin
      tick();
      if (w == 63) check("to_err_pre", 32'(bus.timeout_err), 0);
      if (w == 64) check("to_err", 32'(bus.timeout_err), 1);
    end
    repeat (4) tick();
    check("to_s1", 32'(bus.rst_out_n), 3);
    wait_done("to_done", 100);
    check("to_sticky", 32'(bus.timeout_err), 1);
    sw_pulse();
    check("to_clear", 32'(bus.timeout_err), 0);
    bus.stage_ready = 3'b111;
    wait_done("to_recover", 40);
`endif

    // Asynchronous reset while in DONE
    n_rst = 1'b0;
    #2;
    check("arst_out", 32'(bus.rst_out_n), 0);
    check("arst_busy", 32'(bus.busy), 1);
    check("arst_done", 32'(bus.seq_done), 0);
    check("arst_err", 32'(bus.timeout_err), 0);
    @(negedge clk);
    n_rst = 1'b1;
    wait_done("arst_recover", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
